// File: rtl/systolic_os_core.sv
// Output-stationary systolic matrix-multiply core.
// Computes C = D x W over k_len beats. Skew is applied internally, the array
// advances only on accepted beats or flush cycles, accumulation saturates, and
// result rows drain one per handshake.
module systolic_os_core #(
  parameter int unsigned ARRAY_SIZE = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 2*DATA_WIDTH+5,
  parameter int unsigned K_WIDTH    = 9
) (
  input  logic                             clk,
  input  logic                             srstn,
  input  logic                             start,
  input  logic [K_WIDTH-1:0]               k_len,
  input  logic                             signed_mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_row,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] d_col,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_row,
  output logic [$clog2(ARRAY_SIZE)-1:0]    out_idx,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned N       = ARRAY_SIZE;
  localparam int unsigned DW      = DATA_WIDTH;
  localparam int unsigned AW      = ACC_WIDTH;
  localparam int unsigned PW      = 2*DATA_WIDTH;
  localparam int unsigned IDX_W   = $clog2(ARRAY_SIZE);
  localparam int unsigned FL_W    = $clog2(2*ARRAY_SIZE);
  localparam int unsigned FL_LAST = 2*ARRAY_SIZE-3;

  localparam logic [AW-1:0] S_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] S_MIN = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [K_WIDTH-1:0] beat_q, beat_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sm_q, sm_d;
  logic               done_d;

  logic               clr;
  logic               inject;
  logic               adv;

  logic [DW-1:0]      d_sk    [N];
  logic [DW-1:0]      w_sk    [N];
  logic [DW-1:0]      a_fwd   [N][N-1];
  logic [DW-1:0]      b_fwd   [N-1][N];
  logic [AW-1:0]      acc_val [N][N];
  logic [N*AW-1:0]    row_sel;

  // One multiply-accumulate with mode-dependent extension and saturation.
  function automatic logic [AW-1:0] mac_step(input logic [AW-1:0] acc,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input logic          sm);
    logic [PW-1:0] a_e;
    logic [PW-1:0] b_e;
    logic [PW-1:0] prod;
    logic [AW-1:0] p_e;
    logic [AW:0]   sum;
    logic [AW-1:0] res;
    if (sm) begin
      a_e = PW'($signed(a));
      b_e = PW'($signed(b));
    end else begin
      a_e = PW'(a);
      b_e = PW'(b);
    end
    prod = a_e * b_e;
    if (sm) begin
      p_e = AW'($signed(prod));
      sum = {acc[AW-1], acc} + {p_e[AW-1], p_e};
      if (sum[AW] != sum[AW-1]) res = sum[AW] ? S_MIN : S_MAX;
      else                      res = sum[AW-1:0];
    end else begin
      p_e = AW'(prod);
      sum = {1'b0, acc} + {1'b0, p_e};
      res = sum[AW] ? '1 : sum[AW-1:0];
    end
    return res;
  endfunction

  assign clr    = (state_q == IDLE) && start;
  assign inject = (state_q == LOAD) && in_valid;
  assign adv    = inject || (state_q == FLUSH);

  // Input skew: lane n is delayed n advances; zeros enter outside LOAD.
  for (genvar n = 0; n < N; n++) begin : g_skew
    logic [DW-1:0] d_in;
    logic [DW-1:0] w_in;
    assign d_in = inject ? d_col[n*DW +: DW] : '0;
    assign w_in = inject ? w_row[n*DW +: DW] : '0;
    if (n == 0) begin : g_direct
      assign d_sk[n] = d_in;
      assign w_sk[n] = w_in;
    end else begin : g_delay
      logic [DW-1:0] d_sr [0:n-1];
      logic [DW-1:0] w_sr [0:n-1];
      // Shift both skew chains once per advance.
      always_ff @(posedge clk) begin
        if (!srstn || clr) begin
          for (int s = 0; s < n; s++) begin
            d_sr[s] <= '0;
            w_sr[s] <= '0;
          end
        end else if (adv) begin
          d_sr[0] <= d_in;
          w_sr[0] <= w_in;
          for (int s = 1; s < n; s++) begin
            d_sr[s] <= d_sr[s-1];
            w_sr[s] <= w_sr[s-1];
          end
        end
      end
      assign d_sk[n] = d_sr[n-1];
      assign w_sk[n] = w_sr[n-1];
    end
  end

  // PE grid: data flows right, weights flow down, sums stay in place.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [DW-1:0] a_cur;
      logic [DW-1:0] b_cur;
      logic [AW-1:0] acc_q;

      if (j == 0) begin : g_a_edge
        assign a_cur = d_sk[i];
      end else begin : g_a_int
        assign a_cur = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_cur = w_sk[j];
      end else begin : g_b_int
        assign b_cur = b_fwd[i-1][j];
      end

      // Accumulate the product of the operands currently at this PE.
      always_ff @(posedge clk) begin
        if (!srstn || clr) acc_q <= '0;
        else if (adv)      acc_q <= mac_step(acc_q, a_cur, b_cur, sm_q);
      end
      assign acc_val[i][j] = acc_q;

      if (j < N-1) begin : g_a_fwd
        logic [DW-1:0] a_q;
        // Pass data to the right-hand neighbour.
        always_ff @(posedge clk) begin
          if (!srstn || clr) a_q <= '0;
          else if (adv)      a_q <= a_cur;
        end
        assign a_fwd[i][j] = a_q;
      end
      if (i < N-1) begin : g_b_fwd
        logic [DW-1:0] b_q;
        // Pass weight to the neighbour below.
        always_ff @(posedge clk) begin
          if (!srstn || clr) b_q <= '0;
          else if (adv)      b_q <= b_cur;
        end
        assign b_fwd[i][j] = b_q;
      end
    end
  end

  // Select the accumulator row that will be presented next.
  always_comb begin
    row_sel = '0;
    for (int j = 0; j < N; j++) row_sel[j*AW +: AW] = acc_val[idx_d][j];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!srstn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, counter and job-parameter logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    idx_d   = idx_q;
    sm_d    = sm_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k_len;
          sm_d    = signed_mode;
          beat_d  = '0;
          flush_d = '0;
          idx_d   = '0;
          state_d = (k_len == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (beat_q == k_q - K_WIDTH'(1)) begin
            state_d = FLUSH;
            flush_d = '0;
          end else begin
            beat_d = beat_q + K_WIDTH'(1);
          end
        end
      end
      FLUSH: begin
        if (flush_q == FL_W'(FL_LAST)) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          flush_d = flush_q + FL_W'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == IDX_W'(N-1)) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      k_q       <= '0;
      beat_q    <= '0;
      flush_q   <= '0;
      idx_q     <= '0;
      sm_q      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_row   <= '0;
    end else begin
      k_q       <= k_d;
      beat_q    <= beat_d;
      flush_q   <= flush_d;
      idx_q     <= idx_d;
      sm_q      <= sm_d;
      in_ready  <= (state_d == LOAD);
      out_valid <= (state_d == DRAIN);
      busy      <= (state_d != IDLE);
      done      <= done_d;
      // A zero-length job drains the freshly cleared array, so present zeros.
      out_row   <= (state_d == DRAIN && state_q != IDLE) ? row_sel : '0;
    end
  end

  assign out_idx = idx_q;

endmodule

// File: doc/systolic_os_core.md
SYSTOLIC_OS_CORE -- requirements
Module: systolic_os_core

Interface
REQ-001 The block SHALL have parameter ARRAY_SIZE, default 8; PE grid is ARRAY_SIZE x ARRAY_SIZE, legal range 2..16.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8; operand width.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+5; accumulator width, legal range >= 2*DATA_WIDTH.
REQ-004 The block SHALL have parameter K_WIDTH, default 9; width of the k_len port.
REQ-005 Reset and clock: reset srstn, synchronous, active-low; clock clk.
REQ-006 Ports, in order (name, direction, width, meaning):
- clk, input, 1, clock.
- srstn, input, 1, synchronous active-low reset.
- start, input, 1, begin job; sampled only in IDLE.
- k_len, input, K_WIDTH, number of accumulation beats; sampled with start.
- signed_mode, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, high only in LOAD.
- w_row, input, ARRAY_SIZE*DATA_WIDTH, lane j = W[t][j]; lane 0 at LSBs.
- d_col, input, ARRAY_SIZE*DATA_WIDTH, lane i = D[i][t]; lane 0 at LSBs.
- out_valid, output, 1, result row valid.
- out_ready, input, 1, downstream accepts the row.
- out_row, output, ARRAY_SIZE*ACC_WIDTH, lane j = C[out_idx][j].
- out_idx, output, clog2(ARRAY_SIZE), row index of out_row.
- busy, output, 1, state != IDLE.
- done, output, 1, one-cycle pulse after the last row is accepted.

Function
REQ-007 The block SHALL compute C[i][j] = sum over t = 0..k_len-1 of D[i][t]*W[t][j], output-stationary, one PE per (i,j).
REQ-008 Operand skew SHALL be internal: d lane i delayed i cycles, w lane j delayed j cycles; data moves right one PE per advance, weights move down one PE per advance.
REQ-009 FSM states SHALL be IDLE, LOAD, FLUSH, DRAIN.
REQ-010 IDLE->LOAD on start with k_len != 0; start also clears all accumulators, the skew registers and the beat counter.
REQ-011 IDLE->DRAIN on start with k_len == 0; all C outputs are zero.
REQ-012 In LOAD, a beat SHALL be accepted when in_valid && in_ready; the array advances exactly once per accepted beat.
REQ-013 In LOAD with in_valid low, the entire array (skew registers, pipes, accumulators) SHALL freeze; no bubble is injected.
REQ-014 LOAD->FLUSH after the k_len-th accepted beat.
REQ-015 FLUSH SHALL advance the array every cycle with zero operands injected for exactly 2*ARRAY_SIZE-2 cycles, then go to DRAIN.
REQ-016 DRAIN SHALL present rows out_idx = 0..ARRAY_SIZE-1 in order with out_valid high; out_idx advances on out_valid && out_ready.
REQ-017 out_row and out_idx SHALL stay stable while out_valid && !out_ready.
REQ-018 Acceptance of row ARRAY_SIZE-1 SHALL return the FSM to IDLE with done high for exactly that next cycle.
REQ-019 Products SHALL be 2*DATA_WIDTH wide, signed or unsigned per the latched signed_mode, then extended (sign- or zero-) to ACC_WIDTH.
REQ-020 Accumulation SHALL saturate: signed mode clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; unsigned mode clamps to 2^ACC_WIDTH-1; no wrap-around.
REQ-021 start outside IDLE SHALL be ignored; k_len and signed_mode changes after the start cycle SHALL be ignored.
REQ-022 Latency: the first out_valid SHALL occur 2*ARRAY_SIZE-1 cycles after the last accepted beat (k_len != 0), or 1 cycle after start (k_len == 0).

Reset
REQ-023 While srstn is low, at the clock edge: FSM->IDLE; accumulators, skew registers and counters cleared; in_ready=0, out_valid=0, out_row=0, out_idx=0, busy=0, done=0.
REQ-024 Reset asserted mid-LOAD, mid-FLUSH or mid-DRAIN SHALL abort the job with no further out_valid or done.

Verification
REQ-025 ARRAY_SIZE=4, unsigned, k_len=4, W=identity, D[i][t]=i*4+t+1, in_valid constant -> rows equal D; out_valid first 7 cycles after the 4th beat; done after row 3.
REQ-026 Signed, DATA_WIDTH=8, k_len=3, all operands -128 -> every C = 49152; all operands 127 and -1 -> every C = -381.
REQ-027 ACC_WIDTH=16, unsigned, k_len=2, all operands 255 -> C clamps to 65535; same stimulus in signed mode with -128*-128 x2 -> C clamps to 32767.
REQ-028 Random in_valid gaps during LOAD and random out_ready stalls during DRAIN -> results identical to the gap-free run; out_row stable during stalls.
REQ-029 k_len=0 -> DRAIN entered 1 cycle after start; 4 zero rows; done pulses once.
REQ-030 srstn low for 1 cycle during FLUSH -> busy=0 next cycle; a following job with k_len=1 and all operands 1 -> all C = 1 with no residue from the aborted job.
